// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: sink-side decoder/checker for a VGA stream.
// Recovers pixel coordinates and colour, pulses on frame start, verifies
// line and frame geometry and reports a timing-lock indication.
//
// oPIX_VALID is a one-cycle qualifier for oX/oY/oB/oG/oR with no ready
// signal: the stream cannot be stalled, so a consumer must take every beat
// on which oPIX_VALID is high; the data outputs hold between beats.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [7:0]  iB,
  input  logic [7:0]  iG,
  input  logic [7:0]  iR,
  output logic        oPIX_VALID,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [7:0]  oB,
  output logic [7:0]  oG,
  output logic [7:0]  oR,
  output logic        oFRAME_START,
  output logic        oLOCKED,
  output logic        oERR_H,
  output logic        oERR_V,
  output logic [15:0] oFRAME_CNT,
  output logic [1:0]  oSTATE
);

  localparam logic [10:0] HT_L   = 11'(H_TOTAL);
  localparam logic [10:0] HA11_L = 11'(H_ACTIVE);
  localparam logic [9:0]  HA_L   = 10'(H_ACTIVE);
  localparam logic [9:0]  VA_L   = 10'(V_ACTIVE);
  localparam logic [9:0]  VT_L   = 10'(V_TOTAL);
  localparam logic [3:0]  LF_L   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [15:0] fcnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        bad_now;

  logic        prev_hs, prev_vs;
  logic [10:0] h_clk, act_px;
  logic        line_act, h_meas_en;
  logic [9:0]  x_cnt, y_cnt, v_lines;
  logic [9:0]  y_after_hs, v_after_hs;
  logic        hs_fall, vs_fall, pix_ok, err_h, err_v;

  assign hs_fall = prev_hs & ~iHS;
  assign vs_fall = prev_vs & ~iVS;
  assign pix_ok  = iBLANK_n && (x_cnt < HA_L) && (y_cnt < VA_L);
  assign oLOCKED = (state_q == LOCKED);
  assign oSTATE  = state_q;

  // Line/frame checks; a coincident HS fall is folded into the ending frame first.
  always_comb begin
    y_after_hs = y_cnt;
    v_after_hs = v_lines;
    if (hs_fall && line_act && (y_cnt != 10'h3FF)) y_after_hs = y_cnt + 10'd1;
    if (hs_fall && (v_lines != 10'h3FF))           v_after_hs = v_lines + 10'd1;
    err_h = hs_fall && h_meas_en &&
            !((h_clk == HT_L) && ((act_px == 11'd0) || (act_px == HA11_L)));
    err_v = vs_fall && (state_q != SEARCH) &&
            !((v_after_hs == VT_L) && (y_after_hs == VA_L));
  end

  // Lock state machine: count good frames, drop lock on any timing error.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    fcnt_d      = oFRAME_CNT;
    frame_bad_d = frame_bad_q;
    bad_now     = frame_bad_q | err_h | err_v;
    if (vs_fall) begin
      frame_bad_d = 1'b0;
      unique case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          good_d  = 4'd0;
        end
        MEASURE: begin
          if (bad_now) begin
            good_d = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LF_L) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bad_now) begin
            state_d = MEASURE;
            good_d  = 4'd0;
          end else begin
            fcnt_d = oFRAME_CNT + 16'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (err_h) begin
      frame_bad_d = 1'b1;
      if (state_q == LOCKED) begin
        state_d = MEASURE;
        good_d  = 4'd0;
      end
    end
  end

  // Lock state register and locked-frame counter.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q     <= SEARCH;
      good_q      <= 4'd0;
      frame_bad_q <= 1'b0;
      oFRAME_CNT  <= 16'd0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
      oFRAME_CNT  <= fcnt_d;
    end
  end

  // Edge detection, line/frame counters and the registered pixel path.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      prev_hs      <= 1'b1;
      prev_vs      <= 1'b1;
      h_clk        <= 11'd0;
      act_px       <= 11'd0;
      line_act     <= 1'b0;
      h_meas_en    <= 1'b0;
      x_cnt        <= 10'd0;
      y_cnt        <= 10'd0;
      v_lines      <= 10'd0;
      oPIX_VALID   <= 1'b0;
      oX           <= 10'd0;
      oY           <= 10'd0;
      oB           <= 8'd0;
      oG           <= 8'd0;
      oR           <= 8'd0;
      oFRAME_START <= 1'b0;
      oERR_H       <= 1'b0;
      oERR_V       <= 1'b0;
    end else begin
      prev_hs      <= iHS;
      prev_vs      <= iVS;
      oPIX_VALID   <= pix_ok;
      oFRAME_START <= vs_fall;
      oERR_H       <= err_h;
      oERR_V       <= err_v;
      if (pix_ok) begin
        oX <= x_cnt;
        oY <= y_cnt;
        oB <= iB;
        oG <= iG;
        oR <= iR;
      end
      if (hs_fall) begin
        h_clk     <= 11'd1;
        act_px    <= 11'd0;
        line_act  <= 1'b0;
        x_cnt     <= 10'd0;
        h_meas_en <= (state_q != SEARCH);
      end else begin
        if (h_clk != 11'h7FF) h_clk <= h_clk + 11'd1;
        if (iBLANK_n && (act_px != 11'h7FF)) act_px <= act_px + 11'd1;
        if (iBLANK_n) line_act <= 1'b1;
        if (pix_ok) x_cnt <= x_cnt + 10'd1;
      end
      if (vs_fall) begin
        y_cnt   <= 10'd0;
        v_lines <= 10'd0;
        if (state_q == SEARCH) h_meas_en <= 1'b0;
      end else begin
        y_cnt   <= y_after_hs;
        v_lines <= v_after_hs;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: randomized frame stream against a timestamp-based
// reference model of the receiver's line/frame rules, plus pixel scoreboard.
module tb_vga_sync_receiver;

  localparam int HA = 16, HT = 24, VA = 8, VT = 12, LF = 2;
  localparam int HSW = 3, H_START = 5, V_START = 3;

  logic        vga_clk = 1'b0;
  logic        rst_n, hs, vs, blank_n;
  logic [7:0]  b, g, r;
  logic        pix_valid, frame_start, locked, err_h, err_v;
  logic [9:0]  ox, oy;
  logic [7:0]  ob, og, orr;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .iVGA_CLK(vga_clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs), .iBLANK_n(blank_n),
    .iB(b), .iG(g), .iR(r),
    .oPIX_VALID(pix_valid), .oX(ox), .oY(oy), .oB(ob), .oG(og), .oR(orr),
    .oFRAME_START(frame_start), .oLOCKED(locked), .oERR_H(err_h), .oERR_V(err_v),
    .oFRAME_CNT(frame_cnt), .oSTATE(dbg_state)
  );

  // Clock
  always #5 vga_clk = ~vga_clk;

  // Scoreboard and counters
  int          n_vec = 0, n_err = 0;
  logic [43:0] exp_q[$];

  // Reference model state (integers and timestamps)
  int          m_cyc = 0, m_last_fall, m_line_px, m_lines, m_rows, m_col, m_good;
  bit          m_prev_hs, m_prev_vs, m_searching, m_locked, m_meas, m_line_act, m_frame_bad;
  logic [15:0] m_frame_cnt;
  logic [43:0] m_last_pix;
  bit          e_fs, e_eh, e_ev, e_pix;

  // Per-frame pixel statistics
  int          fr_px;
  logic [19:0] fr_first, fr_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit fh, fv, bad;
    m_cyc++;
    e_fs = 0; e_eh = 0; e_ev = 0; e_pix = 0;
    if (!rst_n) begin
      m_prev_hs = 1; m_prev_vs = 1; m_searching = 1; m_locked = 0; m_meas = 0;
      m_line_act = 0; m_frame_bad = 0; m_last_fall = m_cyc; m_line_px = 0;
      m_lines = 0; m_rows = 0; m_col = 0; m_good = 0; m_frame_cnt = '0;
      m_last_pix = '0;
      exp_q.delete();
      return;
    end
    fh = m_prev_hs && !hs;
    fv = m_prev_vs && !vs;
    // Pixel acceptance uses the position before any sync event of this clock.
    if (blank_n && m_col < HA && m_rows < VA) begin
      e_pix = 1;
      exp_q.push_back({10'(m_col), 10'(m_rows), b, g, r});
      m_col++;
    end
    if (fh) begin
      if (m_meas && !((m_cyc - m_last_fall) == HT && (m_line_px == 0 || m_line_px == HA)))
        e_eh = 1;
      m_last_fall = m_cyc;
      m_col = 0;
      if (m_line_act) m_rows++;
      m_lines++;
      m_meas = !m_searching;
      m_line_px = 0;
      m_line_act = 0;
    end else if (blank_n) begin
      m_line_px++;
      m_line_act = 1;
    end
    if (fv) begin
      e_fs = 1;
      if (!m_searching && !(m_lines == VT && m_rows == VA)) e_ev = 1;
      m_lines = 0;
      m_rows = 0;
      if (m_searching) begin
        m_searching = 0; m_meas = 0; m_good = 0;
      end else begin
        bad = m_frame_bad || e_eh || e_ev;
        if (m_locked) begin
          if (bad) begin m_locked = 0; m_good = 0; end
          else m_frame_cnt = m_frame_cnt + 16'd1;
        end else if (bad) begin
          m_good = 0;
        end else begin
          m_good++;
          if (m_good == LF) m_locked = 1;
        end
      end
      m_frame_bad = 0;
    end else if (e_eh) begin
      m_frame_bad = 1;
      if (m_locked) begin m_locked = 0; m_good = 0; end
    end
    m_prev_hs = hs;
    m_prev_vs = vs;
  endtask

  task automatic check_outputs();
    logic [43:0] got, want;
    check_eq("frame_start", 64'(frame_start), 64'(e_fs));
    check_eq("err_h", 64'(err_h), 64'(e_eh));
    check_eq("err_v", 64'(err_v), 64'(e_ev));
    check_eq("locked", 64'(locked), 64'(m_locked));
    check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frame_cnt));
    check_eq("pix_valid", 64'(pix_valid), 64'(e_pix));
    got = {ox, oy, ob, og, orr};
    if (pix_valid === 1'b1) begin
      check_eq("pix_q_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check_eq("pixel", 64'(got), 64'(want));
        m_last_pix = want;
      end
      fr_px++;
      if (fr_px == 1) fr_first = {ox, oy};
      fr_last = {ox, oy};
    end else begin
      check_eq("pix_hold", 64'(got), 64'(m_last_pix));
    end
  endtask

  // Driver: one clock of stimulus, then model and compare after the edge.
  task automatic tick(input logic t_hs, input logic t_vs, input logic t_bl,
                      input logic [23:0] t_rgb, input logic t_rst);
    @(negedge vga_clk);
    hs = t_hs; vs = t_vs; blank_n = t_bl; {b, g, r} = t_rgb; rst_n = ~t_rst;
    @(posedge vga_clk);
    #1;
    model_step();
    check_outputs();
  endtask

  // Driver: one frame; negative line indices disable the corresponding fault.
  task automatic send_frame(input int n_lines, input int vs_off, input int bad_line,
                            input int bad_delta, input int extra_line, input int rst_line);
    int len, act_end;
    logic t_hs, t_vs, t_bl, t_rst;
    logic [23:0] rgb;
    fr_px = 0;
    for (int l = 0; l < n_lines; l++) begin
      len = HT + ((l == bad_line) ? bad_delta : 0);
      act_end = H_START + HA + ((l == extra_line) ? 1 : 0);
      for (int p = 0; p < len; p++) begin
        rgb   = 24'($urandom);
        t_hs  = !(p < HSW);
        t_vs  = !((l == 0 && p >= vs_off) || l == 1 || (l == 2 && p < vs_off));
        t_bl  = (l >= V_START) && (l < V_START + VA) && (p >= H_START) && (p < act_end);
        t_rst = (l == rst_line) && (p >= 10) && (p < 13);
        tick(t_hs, t_vs, t_bl, rgb, t_rst);
      end
    end
  endtask

  initial begin
    int kind, vo, d;
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; b = '0; g = '0; r = '0;

    // Reset, then idle
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    check_eq("reset_locked", 64'(locked), 64'd0);
    check_eq("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);

    // Clean frames: lock after 3rd VS fall, first locked count after 4th
    for (int f = 0; f < 3; f++) send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("locked_after_3rd_vs", 64'(locked), 64'd1);
    send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("frame_cnt_after_4th_vs", 64'(frame_cnt), 64'd1);
    check_eq("frame_px_count", 64'(fr_px), 64'(HA * VA));
    check_eq("frame_first_xy", 64'(fr_first), 64'({10'd0, 10'd0}));
    check_eq("frame_last_xy", 64'(fr_last), 64'({10'(HA - 1), 10'(VA - 1)}));

    // Short line while locked, relock after two clean frames
    send_frame(VT, 0, 5, -1, -1, -1);
    check_eq("unlocked_after_short_line", 64'(locked), 64'd0);
    send_frame(VT, 0, -1, 0, -1, -1);
    send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("still_unlocked_1_clean", 64'(locked), 64'd0);
    send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("relocked_2_clean", 64'(locked), 64'd1);

    // Short frame, then over-long active line
    send_frame(VT - 1, 1, -1, 0, -1, -1);
    send_frame(VT, 1, -1, 0, -1, -1);
    check_eq("unlocked_after_short_frame", 64'(locked), 64'd0);
    send_frame(VT, 1, -1, 0, -1, -1);
    send_frame(VT, 1, -1, 0, -1, -1);
    check_eq("relocked_after_short_frame", 64'(locked), 64'd1);
    send_frame(VT, 0, -1, 0, V_START + 2, -1);
    check_eq("unlocked_after_long_line", 64'(locked), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(VT, 0, -1, 0, -1, -1);

    // Reset mid-frame: lock returns after 3rd subsequent VS fall
    send_frame(VT, 0, -1, 0, -1, 6);
    send_frame(VT, 0, -1, 0, -1, -1);
    send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("unlocked_2_vs_after_reset", 64'(locked), 64'd0);
    send_frame(VT, 0, -1, 0, -1, -1);
    check_eq("locked_3_vs_after_reset", 64'(locked), 64'd1);

    // Randomized mix of clean and faulty frames
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      vo   = $urandom_range(0, 2);
      d    = $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) d = -d;
      case (kind)
        0: send_frame(VT, vo, $urandom_range(0, VT - 1), d, -1, -1);
        1: send_frame(VT, vo, -1, 0, $urandom_range(V_START, V_START + VA - 1), -1);
        2: send_frame(VT - 1, vo, -1, 0, -1, -1);
        3: send_frame(VT + 1, vo, -1, 0, -1, -1);
        4: send_frame(VT, vo, -1, 0, -1, $urandom_range(3, 9));
        default: send_frame(VT, vo, -1, 0, -1, -1);
      endcase
    end

    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
